// File: rtl/div_sched.sv
// div_sched: two-port front end sharing one radix-2 restoring divider.
// Round-robin arbitration in IDLE, WIDTH shift-subtract cycles in CALC,
// result held on a valid/ready response port in DONE.
module div_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  // The partial remainder is architecturally WIDTH+1 bits, but after each
  // restore step it is always < D, so its top bit is always zero and only
  // WIDTH bits need to be stored.
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_id;
  logic             r_last_grant;
  logic             r_div_zero;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept0;
  logic             w_accept1;
  logic             w_accept;
  logic [WIDTH-1:0] w_dividend;
  logic [WIDTH-1:0] w_divisor;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_idle = (r_state == S_IDLE);

  // Single requester wins outright; on a tie the one not granted last wins.
  assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  // Readies are gated by rst so they read 0 while reset is held.
  assign w_accept0 = rst && w_idle && req0_valid && !w_grant;
  assign w_accept1 = rst && w_idle && req1_valid && w_grant;
  assign w_accept  = w_accept0 || w_accept1;

  assign w_dividend = w_grant ? req1_dividend : req0_dividend;
  assign w_divisor  = w_grant ? req1_divisor  : req0_divisor;

  // One restoring step: shift in the next dividend bit, try subtracting D.
  // When the subtraction succeeds the true difference is < D, so the
  // low WIDTH bits of the modular difference are exact.
  assign w_trial = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_d});
  assign w_diff  = w_trial[WIDTH-1:0] - r_d;

  assign req0_ready    = w_accept0;
  assign req1_ready    = w_accept1;
  assign rsp_valid     = (r_state == S_DONE);
  assign busy          = !w_idle;
  assign rsp_id        = r_id;
  assign rsp_quotient  = r_q;
  assign rsp_remainder = r_rem;
  assign rsp_div_zero  = r_div_zero;

  // Control FSM and divide datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_q          <= '0;
      r_d          <= '0;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_div_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_d          <= w_divisor;
            r_cnt        <= CNT_INIT;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            if (w_divisor == '0) begin
              // Divide-by-zero short-circuits straight to the response.
              r_q        <= '1;
              r_rem      <= w_dividend;
              r_div_zero <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_q        <= w_dividend;
              r_rem      <= '0;
              r_div_zero <= 1'b0;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Results stay put until the consumer takes them.
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_sched.md
# div_sched

Shared iterative unsigned divider with a two-port front end. Two requesters (e.g. the ALU issue slot and the address-generation unit) compete for one radix-2 restoring divide datapath. The block arbitrates round-robin, sequences the WIDTH-cycle shift-subtract, handles divide-by-zero, and holds each result on a single valid/ready response port until it is consumed. One division is in flight at a time.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; while low the block is held in reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle when valid & ready
- req0_dividend  in  WIDTH  requester 0 dividend
- req0_divisor  in  WIDTH  requester 0 divisor
- req1_valid / req1_ready / req1_dividend / req1_divisor  same as port 0, requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result when valid & ready
- rsp_id  out  1  requester index of the result
- rsp_quotient  out  WIDTH  quotient
- rsp_remainder  out  WIDTH  remainder
- rsp_div_zero  out  1  divisor was zero
- busy  out  1  high in CALC and DONE

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Arbitration in IDLE: if exactly one reqN_valid, grant N. If both, grant the requester not granted last. The last_grant register resets to 1, so requester 0 wins the first tie.
- reqN_ready is combinational: high only in IDLE, only for the granted N, and only when reqN_valid. Both readies are 0 outside IDLE and while rst is low.
- Accept (valid & ready):
  - Latch the dividend into the quotient shift register Q.
  - Latch the divisor into D.
  - Clear the partial remainder R (WIDTH+1 bits).
  - Record the id and update last_grant.
  - Load the iteration counter with WIDTH.
- Nonzero divisor: IDLE→CALC.
- Zero divisor: IDLE→DONE directly.
  - quotient = all ones
  - remainder = dividend
  - rsp_div_zero = 1
- Each CALC cycle:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}
  - If R' ≥ {1'b0, D}: R = R' − D and Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = R' and Q = {Q[WIDTH-2:0], 0}.
  - Decrement the counter. When the counter reaches 0, move to DONE.
- DONE:
  - rsp_valid = 1; rsp_quotient = Q, rsp_remainder = R[WIDTH-1:0].
  - All rsp_* outputs are held stable until rsp_ready.
  - On valid & ready: go to IDLE and clear rsp_valid.
- No new request is accepted in the cycle of the response handshake. The earliest accept is the following cycle.
- Unsigned only. Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset values (async, immediate):
  - rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_div_zero=0
  - busy=0, req0_ready=0, req1_ready=0
  - state=IDLE, last_grant=1
- Reset asserted mid-CALC or mid-DONE: the operation is discarded and no response is produced. After deassertion, the block behaves as freshly reset.
- Latency, nonzero divisor: accept on edge E0; rsp_valid rises after edge E0+WIDTH (WIDTH CALC cycles).
- Latency, zero divisor: rsp_valid rises after edge E0.
- Throughput: back-to-back ops with rsp_ready tied high take WIDTH+2 cycles each (accept, WIDTH iterations, DONE/handshake).
- Operand inputs are sampled only at the accept edge. Changes afterwards have no effect.
- Requests arriving while busy wait; reqN_valid must be held by the requester until ready.

## Test plan
- Single op, req0: 100 / 7 with rsp_ready=1 → rsp_valid rises exactly 32 cycles after accept; rsp_quotient=14, rsp_remainder=2, rsp_id=0, rsp_div_zero=0.
- Boundaries:
  - 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0
  - 5 / 9 → q=0, r=5
  - 0x80000000 / 0xFFFFFFFF → q=0, r=0x80000000
- Divide-by-zero: 1234 / 0 on req1 → rsp_valid the cycle after accept; q=0xFFFFFFFF, r=1234, rsp_div_zero=1, rsp_id=1.
- Arbitration: both valid continuously with 8 distinct operand pairs → grants alternate 0,1,0,1,…, starting with 0. Each response id matches its operands. Ready is never high for both ports in the same cycle.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE → rsp_* outputs stable, busy=1, both readies 0. Release → handshake completes, IDLE next cycle, next accept one cycle later.
- Reset mid-CALC: assert rst low 10 cycles into 1000/3 → all outputs 0 immediately. After release, no stale response appears, and a new 9/3 returns q=3, r=0.
